pulse_cmd_ctrl: RTL

Command controller between the osdvu `uart` instance and the pulse-generator configuration. Parses fixed-length command frames from the UART receive strobe and writes or reads a bank of 32-bit configuration registers. Sequences the UART transmitter to return ACK, NAK or read data, one byte at a time. Replaces ad-hoc test logic as the sole owner of the UART `transmit`/`tx_byte` inputs.

---
 rtl/pulse_cmd_pkg.sv | 23 ++
 rtl/cmd_tx_seq.sv | 74 +++++++
 rtl/pulse_cmd_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pulse_cmd_pkg.sv
// rtl/pulse_cmd_pkg.sv - frame constants and state encoding for the UART command controller
package pulse_cmd_pkg;

   localparam logic [7:0] HDR       = 8'hA5;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;
   localparam int         FRAME_LEN = 7;
   localparam int         RSP_MAX   = 5;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      EXEC,
      TX_REQ,
      TX_BUSY,
      TX_DONE
   } cmd_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cmd_tx_seq.sv
// rtl/cmd_tx_seq.sv - response shift register and UART transmit handshake
module cmd_tx_seq
   import pulse_cmd_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [RSP_MAX*8-1:0] bytes_i,
   input  logic [2:0]           count_i,
   input  logic                 is_transmitting_i,
   output logic                 transmit_o,
   output logic [7:0]           tx_byte_o,
   output logic                 done_o
);

   cmd_state_t           state_q, state_d;
   logic [RSP_MAX*8-1:0] shift_q, shift_d;
   logic [2:0]           left_q, left_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         left_q  <= left_d;
      end
   end

   // The head octet is the byte on the wire; it only advances once the UART drops busy.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      left_d     = left_q;
      transmit_o = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_i && (count_i != 3'd0)) begin
               shift_d = bytes_i;
               left_d  = count_i;
               state_d = TX_REQ;
            end
         end
         TX_REQ: begin
            if (!is_transmitting_i) begin
               transmit_o = 1'b1;
               state_d    = TX_BUSY;
            end
         end
         TX_BUSY: begin
            if (is_transmitting_i) state_d = TX_DONE;
         end
         TX_DONE: begin
            if (!is_transmitting_i) begin
               shift_d = {shift_q[RSP_MAX*8-9:0], 8'h00};
               left_d  = left_q - 3'd1;
               if (left_q == 3'd1) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = TX_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_byte_o = shift_q[RSP_MAX*8-1 -: 8];

endmodule

// File: rtl/pulse_cmd_ctrl.sv
// rtl/pulse_cmd_ctrl.sv - UART command frame parser and 32-bit configuration register bank
module pulse_cmd_ctrl
   import pulse_cmd_pkg::*;
#(
   parameter int NREGS   = 8,
   parameter int TIMEOUT = 120000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  received,
   input  logic [7:0]            rx_byte,
   input  logic                  recv_error,
   input  logic                  is_transmitting,
   output logic                  transmit,
   output logic [7:0]            tx_byte,
   output logic [NREGS*32-1:0]   cfg_flat,
   output logic                  cfg_wr,
   output logic                  busy,
   output logic [7:0]            err_cnt
);

   localparam int            IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [2:0]    LAST_IDX = 3'(FRAME_LEN - 1);

   cmd_state_t                 state_q, state_d;
   logic [2:0]                 idx_q, idx_d;
   logic [7:0]                 addr_q, addr_d;
   logic [31:0]                data_q, data_d;
   logic [7:0]                 chk_q, chk_d;
   logic                       good_q, good_d;
   logic [CW-1:0]              tmo_q, tmo_d;
   logic [7:0]                 err_q, err_d;
   logic                       wr_q, wr_d;
   logic [NREGS-1:0][31:0]     regs_q;
   logic [IW-1:0]              ridx;

   logic                       seq_load;
   logic [RSP_MAX*8-1:0]       seq_bytes;
   logic [2:0]                 seq_count;
   logic                       seq_done;

   assign ridx = IW'(addr_q[6:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         chk_q   <= '0;
         good_q  <= 1'b0;
         tmo_q   <= '0;
         err_q   <= '0;
         wr_q    <= 1'b0;
         regs_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         chk_q   <= chk_d;
         good_q  <= good_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         if (wr_d) regs_q[ridx] <= data_q;
      end
   end

   // The write commits on the CHK strobe so EXEC already sees the new register value.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      data_d    = data_q;
      chk_d     = chk_q;
      good_d    = good_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      wr_d      = 1'b0;
      seq_load  = 1'b0;
      seq_bytes = {ACK, regs_q[ridx]};
      seq_count = 3'd0;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (received && (rx_byte == HDR)) begin
               idx_d   = 3'd1;
               chk_d   = 8'h00;
               state_d = RX;
            end
         end
         RX: begin
            if (recv_error || (!received && (tmo_q == TO_LAST))) begin
               err_d   = sat_inc(err_q);
               state_d = IDLE;
            end else if (received) begin
               tmo_d = '0;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd1) addr_d = rx_byte;
               else if (idx_q != LAST_IDX) data_d = {data_q[23:0], rx_byte};
               if (idx_q == LAST_IDX) begin
                  good_d  = (chk_q == rx_byte);
                  wr_d    = (chk_q == rx_byte) && !addr_q[7];
                  state_d = EXEC;
               end else begin
                  chk_d = chk_q ^ rx_byte;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         EXEC: begin
            seq_load = 1'b1;
            state_d  = TX_REQ;
            if (!good_q) begin
               err_d     = sat_inc(err_q);
               seq_bytes = {NAK, 32'h0};
               seq_count = 3'd1;
            end else if (addr_q[7]) begin
               seq_count = 3'd5;
            end else begin
               seq_count = 3'd1;
            end
         end
         TX_REQ, TX_BUSY, TX_DONE: begin
            if (seq_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   cmd_tx_seq u_tx_seq (
      .clk_i             (clk),
      .rst_i             (rst),
      .load_i            (seq_load),
      .bytes_i           (seq_bytes),
      .count_i           (seq_count),
      .is_transmitting_i (is_transmitting),
      .transmit_o        (transmit),
      .tx_byte_o         (tx_byte),
      .done_o            (seq_done)
   );

   assign cfg_flat = regs_q;
   assign cfg_wr   = wr_q;
   assign busy     = (state_q != IDLE);
   assign err_cnt  = err_q;

endmodule
